// File: rtl/jtkunio_obj_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : jtkunio_obj_scan                                                |
// | Brief  : Per-line object scanner: walks the object table, fetches sprite |
// |          rows from ROM and writes opaque pixels to the line buffer.      |
// |          Optional macro JTKUNIO_OBJ_TALL_EN enables 16x32 sprites.       |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module jtkunio_obj_scan #(
    parameter int OBJMAX = 128
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs,
    input  logic [7:0]  vrender,
    input  logic        flip,
    output logic [9:0]  scan_addr,
    input  logic [15:0] scan_dout,
    output logic        rom_cs,
    output logic [17:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_ok,
    output logic [8:0]  buf_addr,
    output logic [6:0]  buf_data,
    output logic        buf_we,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_RD0  = 4'd1,
        ST_WT0  = 4'd2,
        ST_CHK  = 4'd3,
        ST_RD1  = 4'd4,
        ST_RD2  = 4'd5,
        ST_REQ  = 4'd6,
        ST_DRAW = 4'd7,
        ST_DONE = 4'd8
    } state_t;

    localparam logic [6:0] c_LAST_OBJ = 7'(OBJMAX - 1);

    state_t      r_state, w_state_nxt;
    logic [6:0]  r_obj;
    logic [4:0]  r_dy;
    logic        r_hflip, r_tall, r_first, r_k;
    logic [2:0]  r_pal, r_cnt;
    logic [8:0]  r_x;
    logic [31:0] r_pix;

    logic [7:0]  w_dy;
    logic        w_tall_bit, w_hit, w_last, w_capture;
    logic [1:0]  w_word;
    logic [12:0] w_code;
    logic [2:0]  w_nib;
    logic [3:0]  w_pxl;
    logic [8:0]  w_xpix;
    logic        w_unused;

`ifdef JTKUNIO_OBJ_TALL_EN
    assign w_tall_bit = scan_dout[11];
`else
    assign w_tall_bit = 1'b0;
`endif
    assign w_unused  = &{1'b0, scan_dout[11:10]};

    assign w_dy      = vrender - scan_dout[7:0];
    assign w_hit     = scan_dout[8] && (w_dy < (w_tall_bit ? 8'd32 : 8'd16));
    assign w_last    = (r_obj == c_LAST_OBJ);
    assign w_capture = (r_state == ST_REQ) && !r_first && rom_ok;
    // tall sprites pick the upper or lower 16-row block through code[0]
    assign w_code    = {scan_dout[12:1], r_tall ? r_dy[4] : scan_dout[0]};

    // RAM has one cycle of read latency, so the address runs one word ahead
    always_comb begin
        w_word = 2'd0;
        case (r_state)
            ST_CHK:  w_word = w_hit ? 2'd1 : 2'd0;
            ST_RD1:  w_word = 2'd2;
            default: w_word = 2'd0;
        endcase
    end
    assign scan_addr = {1'b0, r_obj, w_word};

    assign w_nib    = r_hflip ? ~r_cnt : r_cnt;
    assign w_pxl    = r_pix[{w_nib, 2'b00} +: 4];
    assign w_xpix   = r_x + {5'd0, r_k, r_cnt};
    assign buf_we   = (r_state == ST_DRAW) && (w_pxl != 4'd0);
    assign buf_addr = (r_state == ST_DRAW) ? (flip ? ~w_xpix : w_xpix) : 9'd0;
    assign buf_data = (r_state == ST_DRAW) ? {r_pal, w_pxl} : 7'd0;
    assign busy     = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        if (hs) begin
            w_state_nxt = ST_RD0;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_RD0:  w_state_nxt = ST_WT0;
                ST_WT0:  w_state_nxt = ST_CHK;
                ST_CHK:  w_state_nxt = w_hit ? ST_RD1 : (w_last ? ST_DONE : ST_RD0);
                ST_RD1:  w_state_nxt = ST_RD2;
                ST_RD2:  w_state_nxt = ST_REQ;
                ST_REQ:  w_state_nxt = w_capture ? ST_DRAW : ST_REQ;
                ST_DRAW: begin
                    if (r_cnt == 3'd7)
                        w_state_nxt = !r_k ? ST_REQ : (w_last ? ST_DONE : ST_RD0);
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_obj    <= 7'd0;
            r_dy     <= 5'd0;
            r_hflip  <= 1'b0;
            r_tall   <= 1'b0;
            r_first  <= 1'b0;
            r_k      <= 1'b0;
            r_pal    <= 3'd0;
            r_cnt    <= 3'd0;
            r_x      <= 9'd0;
            r_pix    <= 32'd0;
            rom_cs   <= 1'b0;
            rom_addr <= 18'd0;
        end else begin
            r_state <= w_state_nxt;
            rom_cs  <= (w_state_nxt == ST_REQ);
            // marks the REQ cycle in which rom_ok is still stale
            r_first <= (w_state_nxt == ST_REQ) && (r_state != ST_REQ);
            if (hs) begin
                r_obj <= 7'd0;
            end else begin
                case (r_state)
                    ST_CHK: begin
                        r_dy    <= w_dy[4:0];
                        r_hflip <= scan_dout[9];
                        r_tall  <= w_tall_bit;
                        r_pal   <= scan_dout[14:12];
                        r_x[8]  <= scan_dout[15];
                        if (!w_hit && !w_last) r_obj <= r_obj + 7'd1;
                    end
                    ST_RD1: r_x[7:0] <= scan_dout[7:0];
                    ST_RD2: begin
                        rom_addr <= {w_code, r_dy[3:0], r_hflip};
                        r_k      <= 1'b0;
                    end
                    ST_REQ: begin
                        if (w_capture) begin
                            r_pix <= rom_data;
                            r_cnt <= 3'd0;
                        end
                    end
                    ST_DRAW: begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (!r_k) begin
                                r_k         <= 1'b1;
                                rom_addr[0] <= ~rom_addr[0];
                            end else if (!w_last) begin
                                r_obj <= r_obj + 7'd1;
                            end
                        end
                    end
                    ST_DONE: r_obj <= 7'd0;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtkunio_obj_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_jtkunio_obj_scan                                             |
// | Brief  : Self-checking bench: object RAM/ROM models plus a reference     |
// |          model of the per-line sprite rendering.                         |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_jtkunio_obj_scan;

    localparam int OBJMAX = 128;
`ifdef JTKUNIO_OBJ_TALL_EN
    localparam bit TALL_EN = 1'b1;
`else
    localparam bit TALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, hs, flip;
    logic [7:0]  vrender;
    logic [9:0]  scan_addr;
    logic [15:0] scan_dout;
    logic        rom_cs, rom_ok, buf_we, busy;
    logic [17:0] rom_addr;
    logic [31:0] rom_data;
    logic [8:0]  buf_addr;
    logic [6:0]  buf_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] obj_ram [0:1023];
    logic [15:0] got_wr[$], exp_wr[$];
    logic [17:0] got_req[$], exp_req[$];

    bit          ovr_en = 1'b0;
    logic [17:0] ovr_addr;
    logic [31:0] ovr_val, ovr_other;
    int          rom_fix = -1;
    int          rom_unstable = 0;

    jtkunio_obj_scan #(.OBJMAX(OBJMAX)) dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vrender(vrender), .flip(flip),
        .scan_addr(scan_addr), .scan_dout(scan_dout),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) scan_dout <= obj_ram[scan_addr];

    function automatic logic [31:0] rom_word(input logic [17:0] a);
        logic [31:0] h, m;
        if (ovr_en) return (a == ovr_addr) ? ovr_val : ovr_other;
        h = ({14'd0, a} ^ 32'h5A17_C3E1) * 32'h9E37_79B1;
        h = h ^ (h >> 13);
        m = h * 32'h85EB_CA6B;
        for (int i = 0; i < 8; i++) if (!m[i + 20]) h[4*i +: 4] = 4'h0;
        return h;
    endfunction

    // ROM slot: stale rom_ok on the first request cycle, then a random wait
    initial begin
        bit          act;
        logic [17:0] cur;
        int          wt;
        act = 1'b0; cur = '0; wt = 0;
        rom_ok = 1'b0; rom_data = '0;
        forever begin
            @(negedge clk);
            if (rom_cs && act && rom_addr != cur) rom_unstable++;
            if (!rom_cs) begin
                act = 1'b0; rom_ok = 1'b0;
            end else if (!act) begin
                act = 1'b1; cur = rom_addr;
                got_req.push_back(rom_addr);
                wt = (rom_fix >= 0) ? rom_fix : int'($urandom_range(0, 4));
                rom_ok = 1'b1; rom_data = ~rom_word(rom_addr);
            end else if (wt == 0) begin
                rom_ok = 1'b1; rom_data = rom_word(cur);
            end else begin
                wt--; rom_ok = 1'b0; rom_data = $urandom;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (buf_we) got_wr.push_back({buf_addr, buf_data});
    end

    // Reference: each hit sprite is 16 screen columns drawn left to right
    function automatic void build_expect(input logic [7:0] vr, input bit fl);
        logic [15:0] w0, w1, w2;
        logic [31:0] word;
        int dy, code, s, addr, pix, x;
        bit tall;
        exp_wr.delete(); exp_req.delete();
        for (int n = 0; n < OBJMAX; n++) begin
            w0 = obj_ram[4*n]; w1 = obj_ram[4*n+1]; w2 = obj_ram[4*n+2];
            dy   = (int'(vr) - int'(w0[7:0])) & 255;
            tall = TALL_EN && w0[11];
            code = int'(w2[12:0]);
            if (w0[8] && dy < (tall ? 32 : 16)) begin
                if (tall) code = (code / 2) * 2 + dy / 16;
                for (int c = 0; c < 16; c++) begin
                    s    = w0[9] ? 15 - c : c;
                    addr = code * 32 + (dy % 16) * 2 + s / 8;
                    word = rom_word(18'(addr));
                    pix  = int'((word >> (4 * (s % 8))) & 32'hF);
                    x    = (int'({w0[15], w1[7:0]}) + c) % 512;
                    if (c % 8 == 0) exp_req.push_back(18'(addr));
                    if (pix != 0) exp_wr.push_back({9'(fl ? 511 - x : x), w0[14:12], 4'(pix)});
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " scan_addr"}, 32'(scan_addr), 0);
        check({tag, " rom_cs"},    32'(rom_cs), 0);
        check({tag, " rom_addr"},  32'(rom_addr), 0);
        check({tag, " buf_addr"},  32'(buf_addr), 0);
        check({tag, " buf_data"},  32'(buf_data), 0);
        check({tag, " buf_we"},    32'(buf_we), 0);
        check({tag, " busy"},      32'(busy), 0);
    endtask

    task automatic compare_scan(input string tag);
        check({tag, " req count"}, got_req.size(), exp_req.size());
        for (int i = 0; i < exp_req.size() && i < got_req.size(); i++)
            check({tag, " req addr"}, 32'(got_req[i]), 32'(exp_req[i]));
        check({tag, " write count"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check({tag, " write"}, 32'(got_wr[i]), 32'(exp_wr[i]));
        check({tag, " rom stable"}, rom_unstable, 0);
    endtask

    task automatic clear_table();
        for (int i = 0; i < 1024; i++) obj_ram[i] = 16'h0000;
    endtask

    task automatic set_obj(input int n, input logic [7:0] y, input logic [8:0] x,
                           input logic [12:0] code, input logic [2:0] pal,
                           input bit hf, input bit tall);
        obj_ram[4*n]   = {x[8], pal, tall, 1'b0, hf, 1'b1, y};
        obj_ram[4*n+1] = {8'h00, x[7:0]};
        obj_ram[4*n+2] = {3'b000, code};
    endtask

    task automatic pulse_hs();
        @(negedge clk); hs = 1'b1;
        @(negedge clk); hs = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 5000) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_scan(input logic [7:0] vr, input bit fl, output int cycles);
        vrender = vr; flip = fl;
        build_expect(vr, fl);
        got_wr.delete(); got_req.delete(); rom_unstable = 0;
        pulse_hs();
        wait_idle(cycles);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [7:0] vr, y;
        logic [15:0] w;
        rst_n = 1'b0; hs = 1'b0; vrender = 8'd0; flip = 1'b0;
        ovr_addr = '0; ovr_val = '0; ovr_other = '0;
        clear_table();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle busy", 32'(busy), 0);

        // all entries disabled, other bits random
        for (int n = 0; n < OBJMAX; n++) begin
            obj_ram[4*n]   = 16'($urandom) & 16'hFEFF;
            obj_ram[4*n+1] = 16'($urandom);
            obj_ram[4*n+2] = 16'($urandom);
        end
        run_scan(8'h40, 1'b0, cyc);
        check("empty busy cycles", cyc, 385);
        compare_scan("empty");

        clear_table();
        set_obj(0, 8'h20, 9'h040, 13'h155, 3'd5, 1'b0, 1'b0);
        ovr_en = 1'b1; ovr_addr = 18'h2AA6;
        ovr_val = 32'h8765_4321; ovr_other = 32'h8765_4321;
        rom_fix = 0;
        run_scan(8'h23, 1'b0, cyc);
        check("basic busy cycles", cyc, 407);
        check("basic req0", 32'(got_req[0]), 32'h2AA6);
        check("basic req1", 32'(got_req[1]), 32'h2AA7);
        check("basic first px", 32'(got_wr[0]), 32'({9'h040, 7'h51}));
        check("basic px7", 32'(got_wr[7]), 32'({9'h047, 7'h58}));
        compare_scan("basic");

        set_obj(0, 8'h20, 9'h040, 13'h155, 3'd5, 1'b1, 1'b0);
        run_scan(8'h23, 1'b1, cyc);
        check("hflip req0", 32'(got_req[0]), 32'h2AA7);
        check("hflip first px", 32'(got_wr[0]), 32'({9'h1BF, 7'h58}));
        compare_scan("hflip");

        set_obj(0, 8'h20, 9'h040, 13'h155, 3'd5, 1'b0, 1'b0);
        ovr_val = 32'h0000_0F00; ovr_other = 32'h0;
        rom_fix = 5;
        run_scan(8'h23, 1'b0, cyc);
        check("slow rom busy cycles", cyc, 417);
        check("single px count", got_wr.size(), 1);
        check("single px", 32'(got_wr[0]), 32'({9'h042, 7'h5F}));
        compare_scan("slow rom");

        ovr_en = 1'b0; rom_fix = -1;
        clear_table();
        set_obj(0, 8'hF8, 9'h100, 13'h0AB, 3'd2, 1'b0, 1'b0);
        run_scan(8'h05, 1'b0, cyc);
        check("wrap req count", got_req.size(), 2);
        check("wrap req0", 32'(got_req[0]), 32'({13'h0AB, 4'hD, 1'b0}));
        compare_scan("wrap");

        clear_table();
        set_obj(0, 8'h10, 9'h080, 13'h154, 3'd3, 1'b0, 1'b1);
        set_obj(6, 8'h1A, 9'h1F8, 13'h033, 3'd6, 1'b1, 1'b0);
        run_scan(8'h23, 1'b0, cyc);
        check("tall req count", got_req.size(), TALL_EN ? 4 : 2);
        check("tall req0", 32'(got_req[0]), TALL_EN ? 32'h2AA6 : 32'({13'h033, 4'h9, 1'b1}));
        compare_scan("tall");

        for (int it = 0; it < 6; it++) begin
            vr = 8'($urandom);
            for (int n = 0; n < OBJMAX; n++) begin
                w = 16'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    y = vr - 8'($urandom_range(0, 40));
                    w[8] = 1'b1; w[7:0] = y;
                end else begin
                    w[8] = 1'b0;
                end
                obj_ram[4*n]   = w;
                obj_ram[4*n+1] = 16'($urandom);
                obj_ram[4*n+2] = 16'($urandom);
            end
            run_scan(vr, 1'($urandom), cyc);
            check("random scan ended", 32'(busy), 0);
            compare_scan("random");
        end

        // abort a hit in REQ; only object 3 hits
        clear_table();
        set_obj(3, 8'h20, 9'h0C0, 13'h0F0, 3'd1, 1'b0, 1'b0);
        vrender = 8'h25; flip = 1'b0;
        build_expect(8'h25, 1'b0);
        pulse_hs();
        cyc = 0;
        while (!rom_cs && cyc < 200) begin cyc++; @(negedge clk); end
        check("abort reached req", 32'(rom_cs), 1);
        hs = 1'b1;
        @(negedge clk);
        hs = 1'b0;
        check("abort rom_cs", 32'(rom_cs), 0);
        check("abort buf_we", 32'(buf_we), 0);
        check("abort busy", 32'(busy), 1);
        check("abort scan_addr", 32'(scan_addr), 0);
        got_req.delete(); got_wr.delete(); rom_unstable = 0;
        wait_idle(cyc);
        check("abort scan ended", 32'(busy), 0);
        compare_scan("abort");

        // reset while drawing
        ovr_en = 1'b1; ovr_addr = 18'h0; ovr_val = 32'h1111_1111; ovr_other = 32'h1111_1111;
        pulse_hs();
        cyc = 0;
        while (!buf_we && cyc < 1000) begin cyc++; @(negedge clk); end
        check("reached draw", 32'(buf_we), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset in draw");
        rst_n = 1'b1;
        ovr_en = 1'b0;
        run_scan(8'h25, 1'b0, cyc);
        compare_scan("after reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtkunio_obj_scan.md
# jtkunio_obj_scan

Sprite line scanner for the Kunio object layer: the read side of the 2 kB object RAM scan port. On each line-start strobe it walks the object table, finds the sprites that cover the next line, fetches their pixel rows from the object ROM and writes opaque pixels into an external line buffer. It sits between the object RAM scan port, the SDRAM ROM slot and the object line buffer.

## Interface
Parameters:
- OBJMAX, 128: number of table entries scanned per line (1..128).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- hs  input  1  line-start strobe, one clk wide
- vrender  input  8  line being prepared; already vertically flip-adjusted
- flip  input  1  horizontal screen flip
- scan_addr  output  10  object RAM word address
- scan_dout  input  16  object RAM word; valid one clk after scan_addr
- rom_cs  output  1  ROM request
- rom_addr  output  18  ROM 32-bit word address
- rom_data  input  32  ROM data
- rom_ok  input  1  ROM data valid
- buf_addr  output  9  line buffer X
- buf_data  output  7  {pal[2:0], pxl[3:0]}
- buf_we  output  1  line buffer write
- busy  output  1  high while a line scan is in progress

## Operation
- Object n uses words {n[6:0],2'b00..11}:
  - w0[7:0]: Y. w0[8]: enable. w0[9]: hflip. w0[11]: tall. w0[14:12]: palette. w0[15]: X[8].
  - w1[7:0]: X[7:0].
  - w2[12:0]: code. w3: unused.
- Hit test: dy = vrender − Y, 8-bit wrap-around. Hit when enable=1 and dy<16 (dy<32 if tall). Disabled objects are skipped without reading w1/w2.
- Row: r = dy[3:0] for normal sprites. Tall sprites use code {code[12:1], dy[4]}.
- rom_addr = {code, r, half}. half 0 is the left 8 pixels and half 1 the right 8. With hflip, half 1 is fetched first.
- Pixel i (0..7) = rom_data[4i+3:4i]. Without hflip it is drawn at X+8·k+i, where k is the draw order of the half. With hflip the nibble order is reversed.
- Pixel value 0 is transparent: buf_we stays 0 for that pixel, but the cycle is still spent.
- buf_addr = flip ? ~(xpix[8:0]) : xpix[8:0]. xpix wraps at 9 bits.
- Objects are drawn in ascending index order. Overwrite priority is the buffer's concern.
- FSM states:
  - IDLE: hs moves to RD0.
  - RD0: drive w0 address, then WT0.
  - WT0 → CHK.
  - CHK: miss → next object, or DONE when n = OBJMAX−1. Hit → RD1.
  - RD1 → RD2: latch X from w1.
  - RD2 → REQ: latch code from w2.
  - REQ: rom_cs=1 until accepted, then DRAW.
  - DRAW: 8 cycles. Then REQ for the second half, or next object.
  - DONE → IDLE.
- ROM handshake: rom_addr and rom_cs stay stable while in REQ. rom_ok is ignored in the first REQ cycle after rom_addr changes. Data is captured on the first later cycle with rom_ok=1. rom_cs drops in the capture cycle.
- hs while busy aborts the current scan. Next cycle: restart at object 0, rom_cs=0, buf_we=0. No partial pixel group is completed.
- busy=1 from the cycle after hs until DONE.

## Timing
- Reset values: scan_addr=0, rom_cs=0, rom_addr=0, buf_addr=0, buf_data=0, buf_we=0, busy=0, FSM=IDLE.
- Miss costs 3 clk (RD0, WT0, CHK).
- Hit costs 3 + 2 clk (RD1, RD2), then per half: REQ (at least 2 clk) + 8 DRAW clk.
- buf_we for pixel 0 of a group asserts the cycle after capture. One pixel per clk.
- Empty table with OBJMAX=128: busy high for 384 clk + 1 DONE clk.

## Configuration
- JTKUNIO_OBJ_TALL_EN defined: the w0[11] tall bit enables 16×32 sprites as described above.
- JTKUNIO_OBJ_TALL_EN undefined: w0[11] is ignored; every sprite is 16×16, with hit when dy<16 and code used unmodified.

## Test plan
- All objects disabled, hs pulse → no rom_cs, no buf_we; busy high for exactly 385 clk.
- Object 0: Y=0x20, X=0x040, code=0x155, pal=5. vrender=0x23 → rom_addr {0x155,3,0} then {0x155,3,1}. rom_data=0x87654321 → buf_addr 0x40..0x47 get data 0x51..0x58.
- Same object with hflip=1 → half 1 fetched first; pixel nibble 7 lands at X=0x40. flip=1 → buf_addr=~0x040=0x1BF for the first pixel.
- rom_data=0x00000F00 → only one buf_we pulse: pixel 2, buf_data={pal,4'hF}. rom_ok delayed 5 clk → rom_cs and rom_addr stay stable until capture.
- Y=0xF8, vrender=0x05 → dy=0x0D, hit (wrap). Tall object, dy=0x13 → hit with JTKUNIO_OBJ_TALL_EN and code[0]=1; miss without the macro.
- hs during a hit's REQ, and rst_n=0 during DRAW → hs: restart at object 0 with rom_cs and buf_we low next clk; reset: all outputs at reset values next clk.
